// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for an 8-bit instruction memory.
// It resolves PC-relative jumps, detects the jump-to-self halt idiom, and supports single-step operation.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] instruction,
    input  logic       stall,
    output logic [7:0] Read_Address,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic       halted,
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_JMP   = 2'b11;
    localparam logic [7:0] HALT_OP  = {OP_JMP, 6'b111111};

    state_t     state;
    logic [7:0] next_pc;
    logic [7:0] fetch_target;

    // The jump target is PC + 1 + sign-extended 6-bit offset, all modulo 256.
    always_comb begin
        fetch_target = Read_Address + 8'd1;
        if (instruction[7:6] == OP_JMP) begin
            fetch_target = Read_Address + 8'd1 + {{2{instruction[5]}}, instruction[5:0]};
        end
    end

    // NOTE: every register here uses non-blocking assignment, so all of them
    // update together on the edge and none can see another's new value in the same cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            Read_Address <= RESET_PC;
            next_pc      <= RESET_PC;
            ir           <= 8'h00;
            ir_valid     <= 1'b0;
            halted       <= 1'b0;
            instr_count  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run || step) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    ir       <= instruction;
                    next_pc  <= fetch_target;
                    ir_valid <= 1'b1;
                    state    <= EXEC;
                end

                EXEC: begin
                    // A stall takes priority, even over a halting instruction.
                    if (!stall) begin
                        instr_count <= instr_count + 8'd1;
                        ir_valid    <= 1'b0;
                        if (ir == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            Read_Address <= next_pc;
                            state        <= run ? FETCH : IDLE;
                        end
                    end
                end

                HALT: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of per-cycle vectors followed by hand-written corner sequences.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       RST;
    logic       run;
    logic       step;
    logic       stall;
    logic [7:0] instruction;
    logic [7:0] Read_Address;
    logic [7:0] ir;
    logic       ir_valid;
    logic       halted;
    logic [7:0] instr_count;

    logic [7:0] mem [256];

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       run;
        logic       step;
        logic       stall;
        logic [7:0] addr;
        logic [7:0] ir;
        logic       valid;
        logic [7:0] cnt;
        logic       halt;
    } vec_t;

    vec_t vecs [29];

    fetch_sequencer #(.RESET_PC(8'h00)) dut (
        .clk          (clk),
        .RST          (RST),
        .run          (run),
        .step         (step),
        .instruction  (instruction),
        .stall        (stall),
        .Read_Address (Read_Address),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    assign instruction = mem[Read_Address];

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        stall = 1'b0;
        RST   = 1'b1;
        tick();
        RST   = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    function automatic vec_t v(input logic r, input logic s, input logic st,
                               input logic [7:0] a, input logic [7:0] i, input logic vl,
                               input logic [7:0] c, input logic h);
        vec_t t;
        t.run = r; t.step = s; t.stall = st;
        t.addr = a; t.ir = i; t.valid = vl; t.cnt = c; t.halt = h;
        return t;
    endfunction

    initial begin
        // Program: straight-line code, forward jumps to 0x10 and 0x14, a back jump to 5, then a halt at 7.
        clear_mem();
        mem[8'h00] = 8'h01;
        mem[8'h01] = 8'h42;
        mem[8'h02] = 8'h83;
        mem[8'h03] = 8'h00;
        mem[8'h04] = 8'hCB;  // JMP +11 -> 0x10
        mem[8'h10] = 8'hC3;  // JMP +3  -> 0x14
        mem[8'h14] = 8'hF0;  // JMP -16 -> 0x05
        mem[8'h05] = 8'h15;
        mem[8'h06] = 8'h2A;
        mem[8'h07] = 8'hFF;  // jump-to-self

        //               run step stall addr   ir     vld cnt    halt
        vecs[0]  = v(1, 0, 0, 8'h00, 8'h00, 0, 8'd0,  0);
        vecs[1]  = v(1, 0, 0, 8'h00, 8'h01, 1, 8'd0,  0);
        vecs[2]  = v(1, 0, 0, 8'h01, 8'h01, 0, 8'd1,  0);
        vecs[3]  = v(1, 0, 0, 8'h01, 8'h42, 1, 8'd1,  0);
        vecs[4]  = v(1, 0, 0, 8'h02, 8'h42, 0, 8'd2,  0);
        vecs[5]  = v(1, 0, 0, 8'h02, 8'h83, 1, 8'd2,  0);
        vecs[6]  = v(1, 0, 1, 8'h02, 8'h83, 1, 8'd2,  0);
        vecs[7]  = v(1, 0, 1, 8'h02, 8'h83, 1, 8'd2,  0);
        vecs[8]  = v(1, 0, 0, 8'h03, 8'h83, 0, 8'd3,  0);
        vecs[9]  = v(1, 0, 0, 8'h03, 8'h00, 1, 8'd3,  0);
        vecs[10] = v(1, 0, 0, 8'h04, 8'h00, 0, 8'd4,  0);
        vecs[11] = v(1, 0, 0, 8'h04, 8'hCB, 1, 8'd4,  0);
        vecs[12] = v(1, 0, 0, 8'h10, 8'hCB, 0, 8'd5,  0);
        vecs[13] = v(1, 0, 0, 8'h10, 8'hC3, 1, 8'd5,  0);
        vecs[14] = v(1, 0, 0, 8'h14, 8'hC3, 0, 8'd6,  0);
        vecs[15] = v(1, 0, 0, 8'h14, 8'hF0, 1, 8'd6,  0);
        vecs[16] = v(0, 0, 0, 8'h05, 8'hF0, 0, 8'd7,  0);
        vecs[17] = v(0, 0, 0, 8'h05, 8'hF0, 0, 8'd7,  0);
        vecs[18] = v(0, 1, 0, 8'h05, 8'hF0, 0, 8'd7,  0);
        vecs[19] = v(0, 1, 0, 8'h05, 8'h15, 1, 8'd7,  0);
        vecs[20] = v(0, 1, 0, 8'h06, 8'h15, 0, 8'd8,  0);
        vecs[21] = v(0, 0, 0, 8'h06, 8'h15, 0, 8'd8,  0);
        vecs[22] = v(1, 0, 0, 8'h06, 8'h15, 0, 8'd8,  0);
        vecs[23] = v(1, 0, 0, 8'h06, 8'h2A, 1, 8'd8,  0);
        vecs[24] = v(1, 0, 0, 8'h07, 8'h2A, 0, 8'd9,  0);
        vecs[25] = v(1, 0, 0, 8'h07, 8'hFF, 1, 8'd9,  0);
        vecs[26] = v(1, 0, 1, 8'h07, 8'hFF, 1, 8'd9,  0);
        vecs[27] = v(1, 0, 0, 8'h07, 8'hFF, 0, 8'd10, 1);
        vecs[28] = v(1, 1, 0, 8'h07, 8'hFF, 0, 8'd10, 1);

        do_reset();
        check("reset addr",  Read_Address, 8'h00);
        check("reset ir",    ir,           8'h00);
        check("reset valid", {7'd0, ir_valid}, 8'd0);
        check("reset halt",  {7'd0, halted},   8'd0);
        check("reset count", instr_count,  8'd0);

        for (int i = 0; i < 29; i++) begin
            run   = vecs[i].run;
            step  = vecs[i].step;
            stall = vecs[i].stall;
            tick();
            check($sformatf("vec%0d addr", i),  Read_Address,        vecs[i].addr);
            check($sformatf("vec%0d ir", i),    ir,                  vecs[i].ir);
            check($sformatf("vec%0d valid", i), {7'd0, ir_valid},    {7'd0, vecs[i].valid});
            check($sformatf("vec%0d count", i), instr_count,         vecs[i].cnt);
            check($sformatf("vec%0d halt", i),  {7'd0, halted},      {7'd0, vecs[i].halt});
        end

        // Wrap-around up: JMP -2 at 0 reaches 0xFF, a non-jump at 0xFF wraps to 0x00.
        clear_mem();
        mem[8'h00] = 8'hFE;
        mem[8'hFF] = 8'h05;
        do_reset();
        run = 1'b1;
        repeat (3) tick();
        check("wrap jmp to ff", Read_Address, 8'hFF);
        repeat (2) tick();
        check("wrap ff to 00", Read_Address, 8'h00);
        check("wrap count", instr_count, 8'd2);

        // Wrap-around down: JMP -8 at 0x02 lands on 0xFB.
        clear_mem();
        mem[8'h02] = 8'hF8;
        do_reset();
        run = 1'b1;
        repeat (7) tick();
        check("neg wrap addr", Read_Address, 8'hFB);
        check("neg wrap count", instr_count, 8'd3);

        // Five-cycle stall in EXEC holds everything; one retire after release.
        clear_mem();
        mem[8'h00] = 8'h3C;
        do_reset();
        run = 1'b1;
        repeat (2) tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d valid", i), {7'd0, ir_valid}, 8'd1);
            check($sformatf("stall%0d ir", i),    ir,               8'h3C);
            check($sformatf("stall%0d addr", i),  Read_Address,     8'h00);
            check($sformatf("stall%0d count", i), instr_count,      8'd0);
        end
        stall = 1'b0;
        tick();
        check("stall release count", instr_count, 8'd1);
        check("stall release addr",  Read_Address, 8'h01);
        tick();
        check("stall single incr", instr_count, 8'd1);

        // Halt at 0x07 after seven non-jumps, held indefinitely, then async reset mid-cycle.
        clear_mem();
        mem[8'h07] = 8'hFF;
        do_reset();
        run = 1'b1;
        begin
            int budget;
            budget = 0;
            while (!halted && budget < 100) begin
                tick();
                budget++;
            end
            check("halt reached", {7'd0, halted}, 8'd1);
        end
        check("halt addr",  Read_Address, 8'h07);
        check("halt count", instr_count,  8'd8);
        check("halt ir",    ir,           8'hFF);
        check("halt valid", {7'd0, ir_valid}, 8'd0);
        step = 1'b1;
        repeat (10) tick();
        step = 1'b0;
        check("halt held addr",  Read_Address, 8'h07);
        check("halt held count", instr_count,  8'd8);
        check("halt held flag",  {7'd0, halted}, 8'd1);

        #2;
        RST = 1'b1;
        #1;
        check("async rst halted", {7'd0, halted}, 8'd0);
        check("async rst addr",   Read_Address,   8'h00);
        check("async rst count",  instr_count,    8'd0);
        check("async rst ir",     ir,             8'h00);
        tick();
        RST = 1'b0;
        run = 1'b0;
        tick();
        check("post rst idle addr",  Read_Address,     8'h00);
        check("post rst idle valid", {7'd0, ir_valid}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
